// File: rtl/mano_io_pkg.sv
// Shared types, default sizes and the channel priority helper for the MANO I/O controller.
package mano_io_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 4;
  // Upper bound on channel count supported by the priority helper.
  localparam int MAX_CH     = 32;
  localparam int MAX_CH_W   = 5;

  typedef enum logic {
    INT_IDLE    = 1'b0,
    INT_PENDING = 1'b1
  } int_state_t;

  function automatic logic [MAX_CH_W-1:0] lowest_set(input logic [MAX_CH-1:0] vec);
    logic [MAX_CH_W-1:0] idx;
    logic                found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (vec[i] && !found) begin
        idx   = MAX_CH_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mano_io_channel.sv
// One I/O channel: INPR/OUTR buffers, FGI/FGO flags and the device valid/ready handshakes.
module mano_io_channel
  import mano_io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inp_clr,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] ac_in,
  input  logic              dev_in_valid,
  input  logic [DATA_W-1:0] dev_in_data,
  input  logic              dev_out_ready,
  output logic [DATA_W-1:0] inpr,
  output logic [DATA_W-1:0] outr,
  output logic              fgi,
  output logic              fgo,
  output logic              dev_in_ready,
  output logic              dev_out_valid
);

  logic [DATA_W-1:0] inpr_d, inpr_q;
  logic [DATA_W-1:0] outr_d, outr_q;
  logic              fgi_d, fgi_q;
  logic              fgo_d, fgo_q;

  // A full INPR stalls the device, so a same-channel INP clear never races an accept.
  assign dev_in_ready  = ~fgi_q;
  assign dev_out_valid = ~fgo_q;

  always_comb begin
    // NOTE: every signal gets a hold value first so no path through this block infers a latch.
    inpr_d = inpr_q;
    outr_d = outr_q;
    fgi_d  = fgi_q;
    fgo_d  = fgo_q;
    if (dev_in_valid && dev_in_ready) begin
      inpr_d = dev_in_data;
      fgi_d  = 1'b1;
    end else if (inp_clr) begin
      fgi_d  = 1'b0;
    end
    // A CPU write wins over a device accept in the same cycle: the new byte stays pending.
    if (out_wr) begin
      outr_d = ac_in;
      fgo_d  = 1'b0;
    end else if (dev_out_ready && dev_out_valid) begin
      fgo_d  = 1'b1;
    end
  end

  // NOTE: INPR/OUTR are reset too, since their contents are visible on the ports right after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inpr_q <= '0;
      outr_q <= '0;
      fgi_q  <= 1'b0;
      fgo_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      inpr_q <= inpr_d;
      outr_q <= outr_d;
      fgi_q  <= fgi_d;
      fgo_q  <= fgo_d;
    end
  end

  assign inpr = inpr_q;
  assign outr = outr_q;
  assign fgi  = fgi_q;
  assign fgo  = fgo_q;

endmodule

// File: rtl/mano_io_controller.sv
// Multi-channel MANO I/O and interrupt controller: channel muxes, IEN, R flip-flop, priority vector.
// Optional build macro MANO_IO_MASK_EN adds a per-channel interrupt mask register.
module mano_io_controller
  import mano_io_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef MANO_IO_MASK_EN
  input  logic                     mask_wr,
  input  logic [NUM_CH-1:0]        mask_in,
`endif
  input  logic [CH_W-1:0]          io_sel,
  input  logic                     inp_req,
  input  logic                     out_req,
  input  logic [DATA_W-1:0]        ac_in,
  output logic [DATA_W-1:0]        inpr_out,
  output logic                     fgi_sel,
  output logic                     fgo_sel,
  input  logic                     ion_req,
  input  logic                     iof_req,
  input  logic                     int_ack,
  output logic                     ien,
  output logic                     int_pending,
  output logic [CH_W-1:0]          int_vector,
  output logic                     int_is_out,
  input  logic [NUM_CH-1:0]        dev_in_valid,
  input  logic [NUM_CH*DATA_W-1:0] dev_in_data,
  output logic [NUM_CH-1:0]        dev_in_ready,
  output logic [NUM_CH-1:0]        dev_out_valid,
  output logic [NUM_CH*DATA_W-1:0] dev_out_data,
  input  logic [NUM_CH-1:0]        dev_out_ready
);

  logic [DATA_W-1:0] inpr [NUM_CH];
  logic [NUM_CH-1:0] fgi, fgo, mask, request;
  logic [CH_W-1:0]   int_vector_d, int_vector_q;
  logic              int_is_out_d, int_is_out_q;
  logic              ien_d, ien_q;
  int_state_t        state_d, state_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mano_io_channel #(.DATA_W(DATA_W)) u_ch (
      .clk           (clk),
      .reset         (reset),
      .inp_clr       (inp_req && (io_sel == CH_W'(i))),
      .out_wr        (out_req && (io_sel == CH_W'(i))),
      .ac_in         (ac_in),
      .dev_in_valid  (dev_in_valid[i]),
      .dev_in_data   (dev_in_data[i*DATA_W +: DATA_W]),
      .dev_out_ready (dev_out_ready[i]),
      .inpr          (inpr[i]),
      .outr          (dev_out_data[i*DATA_W +: DATA_W]),
      .fgi           (fgi[i]),
      .fgo           (fgo[i]),
      .dev_in_ready  (dev_in_ready[i]),
      .dev_out_valid (dev_out_valid[i])
    );
  end

`ifdef MANO_IO_MASK_EN
  logic [NUM_CH-1:0] mask_d, mask_q;
  assign mask_d = mask_wr ? mask_in : mask_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mask_q <= '1;
    else        mask_q <= mask_d;
  end
  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  assign request = (fgi | fgo) & mask;

  always_comb begin
    inpr_out = '0;
    fgi_sel  = 1'b0;
    fgo_sel  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (io_sel == CH_W'(i)) begin
        inpr_out = inpr[i];
        fgi_sel  = fgi[i];
        fgo_sel  = fgo[i];
      end
    end
  end

  always_comb begin
    ien_d = ien_q;
    if (int_ack || iof_req) ien_d = 1'b0;
    else if (ion_req)       ien_d = 1'b1;
  end

  // R FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= INT_IDLE;
    else        state_q <= state_d;
  end

  // R FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INT_IDLE:    if (ien_q && (|request) && !int_ack) state_d = INT_PENDING;
      INT_PENDING: if (int_ack)                         state_d = INT_IDLE;
      default:     state_d = INT_IDLE;
    endcase
  end

  // R FSM: outputs and vector capture on the IDLE->PENDING edge.
  always_comb begin
    logic [MAX_CH-1:0] req_ext;
    req_ext              = '0;
    req_ext[NUM_CH-1:0]  = request;
    int_vector_d         = int_vector_q;
    int_is_out_d         = int_is_out_q;
    if (state_q == INT_IDLE && state_d == INT_PENDING) begin
      int_vector_d = CH_W'(lowest_set(req_ext));
      int_is_out_d = ~fgi[int_vector_d];
    end
    int_pending = (state_q == INT_PENDING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien_q        <= 1'b0;
      int_vector_q <= '0;
      int_is_out_q <= 1'b0;
    end else begin
      ien_q        <= ien_d;
      int_vector_q <= int_vector_d;
      int_is_out_q <= int_is_out_d;
    end
  end

  assign ien        = ien_q;
  assign int_vector = int_vector_q;
  assign int_is_out = int_is_out_q;

endmodule

// File: tb/tb_mano_io_controller.sv
// Directed self-checking bench for mano_io_controller (4 channels, 8-bit data).
module tb_mano_io_controller;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     mask_wr = 1'b0;
  logic [NUM_CH-1:0]        mask_in = '1;
  logic [CH_W-1:0]          io_sel = '0;
  logic                     inp_req = 1'b0, out_req = 1'b0;
  logic [DATA_W-1:0]        ac_in = '0;
  logic [DATA_W-1:0]        inpr_out;
  logic                     fgi_sel, fgo_sel;
  logic                     ion_req = 1'b0, iof_req = 1'b0, int_ack = 1'b0;
  logic                     ien, int_pending, int_is_out;
  logic [CH_W-1:0]          int_vector;
  logic [NUM_CH-1:0]        dev_in_valid = '0;
  logic [NUM_CH*DATA_W-1:0] dev_in_data = '0;
  logic [NUM_CH-1:0]        dev_in_ready, dev_out_valid;
  logic [NUM_CH*DATA_W-1:0] dev_out_data;
  logic [NUM_CH-1:0]        dev_out_ready = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mano_io_controller #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef MANO_IO_MASK_EN
    .mask_wr       (mask_wr),
    .mask_in       (mask_in),
`endif
    .io_sel        (io_sel),
    .inp_req       (inp_req),
    .out_req       (out_req),
    .ac_in         (ac_in),
    .inpr_out      (inpr_out),
    .fgi_sel       (fgi_sel),
    .fgo_sel       (fgo_sel),
    .ion_req       (ion_req),
    .iof_req       (iof_req),
    .int_ack       (int_ack),
    .ien           (ien),
    .int_pending   (int_pending),
    .int_vector    (int_vector),
    .int_is_out    (int_is_out),
    .dev_in_valid  (dev_in_valid),
    .dev_in_data   (dev_in_data),
    .dev_in_ready  (dev_in_ready),
    .dev_out_valid (dev_out_valid),
    .dev_out_data  (dev_out_data),
    .dev_out_ready (dev_out_ready)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dev_in_valid = 4'hF;
    dev_in_data = 32'hDEADBEEF;
    dev_out_ready = 4'hF;
    repeat (3) tick();
    checks++; if (ien !== 1'b0) begin errors++; $display("FAIL reset_ien: got %0h want 0", ien); end
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0h want 0", int_pending); end
    checks++; if (int_vector !== 2'd0) begin errors++; $display("FAIL reset_vector: got %0h want 0", int_vector); end
    checks++; if (int_is_out !== 1'b0) begin errors++; $display("FAIL reset_is_out: got %0h want 0", int_is_out); end
    checks++; if (dev_out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %0h want 0", dev_out_valid); end
    checks++; if (dev_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", dev_out_data); end
    checks++; if (inpr_out !== 8'h00) begin errors++; $display("FAIL reset_inpr: got %0h want 0", inpr_out); end
    checks++; if ({fgi_sel, fgo_sel} !== 2'b01) begin errors++; $display("FAIL reset_flags: got %0b want 01", {fgi_sel, fgo_sel}); end
    dev_in_valid = '0;
    dev_out_ready = '0;
    reset = 1'b1;
    tick();
    checks++; if (dev_in_ready !== 4'hF) begin errors++; $display("FAIL release_in_ready: got %0h want f", dev_in_ready); end
    checks++; if (dev_out_valid !== 4'h0) begin errors++; $display("FAIL release_out_valid: got %0h want 0", dev_out_valid); end
    checks++; if (inpr_out !== 8'h00) begin errors++; $display("FAIL release_inpr: got %0h want 0", inpr_out); end
  endtask

  task automatic test_input();
    dev_in_valid = 4'b0100;
    dev_in_data = 32'h00A5_0000;
    tick();
    dev_in_valid = '0;
    io_sel = 2'd2;
    #1;
    checks++; if (dev_in_ready !== 4'b1011) begin errors++; $display("FAIL in_ready_full: got %0b want 1011", dev_in_ready); end
    checks++; if (fgi_sel !== 1'b1) begin errors++; $display("FAIL in_fgi_set: got %0h want 1", fgi_sel); end
    checks++; if (inpr_out !== 8'hA5) begin errors++; $display("FAIL in_data: got %0h want a5", inpr_out); end
    // INP while a new byte is offered on the same channel: the byte must wait a cycle.
    inp_req = 1'b1;
    dev_in_valid = 4'b0100;
    dev_in_data = 32'h005A_0000;
    tick();
    inp_req = 1'b0;
    checks++; if (fgi_sel !== 1'b0) begin errors++; $display("FAIL inp_clear: got %0h want 0", fgi_sel); end
    checks++; if (inpr_out !== 8'hA5) begin errors++; $display("FAIL in_blocked: got %0h want a5", inpr_out); end
    tick();
    dev_in_valid = '0;
    checks++; if ({fgi_sel, inpr_out} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL in_next_cycle: got %0h want 15a", {fgi_sel, inpr_out}); end
    inp_req = 1'b1;
    tick();
    // INP on an empty channel has no effect, so the concurrent device byte is taken.
    io_sel = 2'd0;
    dev_in_valid = 4'b0001;
    dev_in_data = 32'h0000_005C;
    tick();
    inp_req = 1'b0;
    dev_in_valid = '0;
    checks++; if ({fgi_sel, inpr_out} !== {1'b1, 8'h5C}) begin errors++; $display("FAIL inp_empty_noeffect: got %0h want 15c", {fgi_sel, inpr_out}); end
    checks++; if (dev_in_ready !== 4'b1110) begin errors++; $display("FAIL in_ready_ch0: got %0b want 1110", dev_in_ready); end
    inp_req = 1'b1;
    tick();
    inp_req = 1'b0;
    checks++; if (dev_in_ready !== 4'hF) begin errors++; $display("FAIL in_all_empty: got %0h want f", dev_in_ready); end
  endtask

  task automatic test_output();
    io_sel = 2'd1;
    out_req = 1'b1;
    ac_in = 8'h3C;
    tick();
    out_req = 1'b0;
    checks++; if (dev_out_valid !== 4'b0010) begin errors++; $display("FAIL out_valid: got %0b want 0010", dev_out_valid); end
    checks++; if (dev_out_data[15:8] !== 8'h3C) begin errors++; $display("FAIL out_data: got %0h want 3c", dev_out_data[15:8]); end
    checks++; if (fgo_sel !== 1'b0) begin errors++; $display("FAIL out_fgo_clr: got %0h want 0", fgo_sel); end
    tick();
    checks++; if (dev_out_valid !== 4'b0010) begin errors++; $display("FAIL out_hold: got %0b want 0010", dev_out_valid); end
    // OUT while FGO=0 overwrites OUTR and leaves FGO clear.
    out_req = 1'b1;
    ac_in = 8'h77;
    tick();
    out_req = 1'b0;
    checks++; if ({fgo_sel, dev_out_data[15:8]} !== {1'b0, 8'h77}) begin errors++; $display("FAIL out_overwrite: got %0h want 077", {fgo_sel, dev_out_data[15:8]}); end
    dev_out_ready = 4'b0010;
    tick();
    dev_out_ready = '0;
    checks++; if (dev_out_valid !== 4'h0) begin errors++; $display("FAIL out_accept_valid: got %0h want 0", dev_out_valid); end
    checks++; if ({fgo_sel, dev_out_data[15:8]} !== {1'b1, 8'h77}) begin errors++; $display("FAIL out_accept_fgo: got %0h want 177", {fgo_sel, dev_out_data[15:8]}); end
  endtask

  task automatic test_interrupt();
    dev_in_valid = 4'b1000;
    dev_in_data = 32'h4200_0000;
    tick();
    dev_in_valid = '0;
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL int_needs_ien: got %0h want 0", int_pending); end
    ion_req = 1'b1;
    tick();
    ion_req = 1'b0;
    checks++; if ({ien, int_pending} !== 2'b10) begin errors++; $display("FAIL ion_set: got %0b want 10", {ien, int_pending}); end
    tick();
    checks++; if ({int_pending, int_vector, int_is_out} !== {1'b1, 2'd0, 1'b1}) begin errors++; $display("FAIL int_capture0: got %0b want 1001", {int_pending, int_vector, int_is_out}); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if ({int_pending, ien, int_vector} !== 4'b0000) begin errors++; $display("FAIL int_ack: got %0b want 0000", {int_pending, ien, int_vector}); end
    // Busy ch0 output and fill ch1 input: ch1 becomes lowest, sourced by FGI.
    io_sel = 2'd0;
    out_req = 1'b1;
    ac_in = 8'h10;
    dev_in_valid = 4'b0010;
    dev_in_data = 32'h0000_1100;
    tick();
    out_req = 1'b0;
    dev_in_valid = '0;
    ion_req = 1'b1;
    tick();
    ion_req = 1'b0;
    tick();
    checks++; if ({int_pending, int_vector, int_is_out} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL int_capture1: got %0b want 1010", {int_pending, int_vector, int_is_out}); end
    int_ack = 1'b1;
    ion_req = 1'b1;
    tick();
    int_ack = 1'b0;
    ion_req = 1'b0;
    checks++; if ({int_pending, ien} !== 2'b00) begin errors++; $display("FAIL ack_beats_ion: got %0b want 00", {int_pending, ien}); end
    checks++; if (int_vector !== 2'd1) begin errors++; $display("FAIL vector_held: got %0h want 1", int_vector); end
  endtask

  task automatic test_ien_priority();
    ion_req = 1'b1;
    tick();
    checks++; if (ien !== 1'b1) begin errors++; $display("FAIL ien_on: got %0h want 1", ien); end
    iof_req = 1'b1;
    tick();
    ion_req = 1'b0;
    iof_req = 1'b0;
    checks++; if (ien !== 1'b0) begin errors++; $display("FAIL iof_beats_ion: got %0h want 0", ien); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL ack_clear: got %0h want 0", int_pending); end
    ion_req = 1'b1;
    tick();
    ion_req = 1'b0;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if ({int_pending, ien} !== 2'b00) begin errors++; $display("FAIL ack_blocks_set: got %0b want 00", {int_pending, ien}); end
  endtask

  task automatic test_back_to_back();
    io_sel = 2'd3;
    inp_req = 1'b1;
    out_req = 1'b1;
    ac_in = 8'h99;
    tick();
    inp_req = 1'b0;
    out_req = 1'b0;
    checks++; if ({fgi_sel, fgo_sel} !== 2'b00) begin errors++; $display("FAIL both_req_flags: got %0b want 00", {fgi_sel, fgo_sel}); end
    checks++; if ({dev_out_valid[3], dev_out_data[31:24]} !== {1'b1, 8'h99}) begin errors++; $display("FAIL both_req_out: got %0h want 199", {dev_out_valid[3], dev_out_data[31:24]}); end
  endtask

`ifdef MANO_IO_MASK_EN
  task automatic test_mask();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int c = 1; c < NUM_CH; c++) begin
      io_sel = CH_W'(c);
      out_req = 1'b1;
      ac_in = 8'(c);
      tick();
    end
    out_req = 1'b0;
    mask_wr = 1'b1;
    mask_in = 4'b1110;
    dev_in_valid = 4'b0001;
    dev_in_data = 32'h0000_0001;
    ion_req = 1'b1;
    tick();
    mask_wr = 1'b0;
    dev_in_valid = '0;
    ion_req = 1'b0;
    repeat (2) tick();
    checks++; if ({ien, int_pending} !== 2'b10) begin errors++; $display("FAIL mask_blocks: got %0b want 10", {ien, int_pending}); end
    mask_wr = 1'b1;
    mask_in = 4'b1111;
    tick();
    mask_wr = 1'b0;
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL mask_write_edge: got %0h want 0", int_pending); end
    tick();
    checks++; if ({int_pending, int_vector, int_is_out} !== {1'b1, 2'd0, 1'b0}) begin errors++; $display("FAIL unmask_irq: got %0b want 1000", {int_pending, int_vector, int_is_out}); end
  endtask
`endif

  initial begin
    test_reset();
    test_input();
    test_output();
    test_interrupt();
    test_ien_priority();
    test_back_to_back();
`ifdef MANO_IO_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
